piso_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one parallel-in/serial-out shifter between NREQ requesters.
- Grants one requester, captures its WIDTH-bit word and shifts it out LSB-first, one bit per clock.
- Frames the output with sof/eof strobes and inserts a programmable idle gap between frames.
- Sits between multiple parallel producers and a single-bit serial link.

---
 rtl/piso_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_piso_tx_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/piso_tx_arbiter.sv
// piso_tx_arbiter: round-robin scheduler that shares one parallel-in/serial-out
// shifter between NREQ requesters. The winner's WIDTH-bit word is shifted out
// LSB-first. The stream is framed with sof/eof, and GAP idle cycles separate
// frames.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   req[NREQ]    per-requester request, held until acked
//   data         requester i word at [i*WIDTH +: WIDTH]
//   ack[NREQ]    one-hot, one-cycle pulse in the frame's first-bit cycle
//   sout         serial bit (0 when sout_valid=0)
//   sout_valid   sout carries a frame bit
//   sof / eof    first / last bit of the frame
//   src_id       owner of the current (or last) frame
//   busy         state != IDLE
module piso_tx_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int GAP   = 1,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       ack,
  output logic                  sout,
  output logic                  sout_valid,
  output logic                  sof,
  output logic                  eof,
  output logic [IDW-1:0]        src_id,
  output logic                  busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAPS} state_t;

  state_t                     state, state_nxt;
  logic [WIDTH-1:0]           shreg;
  logic [CW-1:0]              bitcnt;
  logic [GW-1:0]              gapcnt;
  logic [IDW-1:0]             ptr;
  logic [NREQ-1:0][WIDTH-1:0] dw;
  logic [NREQ-1:0]            mreq;
  logic [IDW:0]               sum;
  logic [IDW-1:0]             win;
  logic                       win_vld, grant, last, gap_done;

  assign dw       = data;
  assign last     = (bitcnt == CW'(WIDTH - 1));
  assign gap_done = (gapcnt == GW'(GAP - 1));

  // A requester acked this cycle still shows a stale req; keep it out of the race.
  assign mreq = req & ~ack;

  // Scan offsets from high to low so the nearest requester at/after ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    sum     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      if (mreq[sum[IDW-1:0]]) begin
        win_vld = 1'b1;
        win     = sum[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: if (win_vld) begin
        grant     = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: if (last) begin
        if (GAP > 0) state_nxt = GAPS;
        else if (win_vld) begin
          // With no gap, the next frame abuts the current one.
          grant     = 1'b1;
          state_nxt = SHIFT;
        end else state_nxt = IDLE;
      end
      GAPS: if (gap_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      bitcnt <= '0;
      gapcnt <= '0;
      ptr    <= '0;
      src_id <= '0;
      ack    <= '0;
    end else begin
      ack <= '0;
      if (grant) begin
        shreg  <= dw[win];
        src_id <= win;
        ptr    <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
        bitcnt <= '0;
        ack    <= NREQ'(1) << win;
      end else if (state == SHIFT) begin
        shreg  <= shreg >> 1;
        bitcnt <= bitcnt + 1'b1;
      end
      if (state == SHIFT && last) gapcnt <= '0;
      else if (state == GAPS)     gapcnt <= gapcnt + 1'b1;
    end
  end

  assign sout_valid = (state == SHIFT);
  assign sout       = sout_valid & shreg[0];
  assign sof        = sout_valid & (bitcnt == '0);
  assign eof        = sout_valid & last;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Directed bench for piso_tx_arbiter. It uses a GAP=1 instance (d=0) and a
// GAP=0 instance (d=1). Expected frames are queued when requests are raised.
// A per-cycle monitor checks each frame's id, spacing, bit count and word
// against the queue.
module tb_piso_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req_z;
  logic [15:0] data;
  logic [3:0]  ack, ack_z;
  logic        sout, sv, sof, eof, busy;
  logic        sout_z, sv_z, sof_z, eof_z, busy_z;
  logic [1:0]  sid, sid_z;

  piso_tx_arbiter #(.NREQ(4), .WIDTH(4), .GAP(1), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack), .sout(sout),
    .sout_valid(sv), .sof(sof), .eof(eof), .src_id(sid), .busy(busy));

  piso_tx_arbiter #(.NREQ(4), .WIDTH(4), .GAP(0), .IDW(2)) dut0 (
    .clk(clk), .rst(rst), .req(req_z), .data(data), .ack(ack_z), .sout(sout_z),
    .sout_valid(sv_z), .sof(sof_z), .eof(eof_z), .src_id(sid_z), .busy(busy_z));

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [3:0] w;
    int         sp;   // expected sof-to-sof spacing, 0 = unchecked
  } exp_t;

  exp_t       q[2][$];
  logic [3:0] acc[2];
  int         nb[2];
  int         last_sof[2];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(int d, int id, logic [3:0] w, int sp);
    exp_t e;
    e.id = id; e.w = w; e.sp = sp;
    q[d].push_back(e);
  endtask

  task automatic mon(int d, logic f_sof, logic f_eof, logic f_sv, logic f_so,
                     logic [1:0] f_id);
    exp_t e;
    if (!f_sv) begin
      chk("idle_quiet", {29'b0, f_so, f_sof, f_eof}, 0);
    end else begin
      if (f_sof) begin
        nb[d] = 0; acc[d] = '0;
        chk("pending_at_sof", q[d].size() > 0, 1);
        if (q[d].size() > 0) begin
          e = q[d][0];
          chk("sof_id", f_id, e.id);
          if (e.sp != 0) chk("spacing", cyc - last_sof[d], e.sp);
        end
        last_sof[d] = cyc;
      end
      if (nb[d] < 4) acc[d][nb[d]] = f_so;
      nb[d]++;
      if (f_eof) begin
        chk("bits", nb[d], 4);
        chk("pending_at_eof", q[d].size() > 0, 1);
        if (q[d].size() > 0) begin
          e = q[d].pop_front();
          chk("word", acc[d], e.w);
          chk("eof_id", f_id, e.id);
        end
      end
    end
  endtask

  // One clock: sample after the edge, monitor both DUTs, requesters drop acked req.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    mon(0, sof, eof, sv, sout, sid);
    mon(1, sof_z, eof_z, sv_z, sout_z, sid_z);
    req   = req & ~ack;
    req_z = req_z & ~ack_z;
  endtask

  task automatic drain(int d, int bound);
    int n = 0;
    while ((q[d].size() > 0 || (d == 0 ? busy : busy_z)) && n < bound) begin
      tick();
      n++;
    end
    chk("drain", q[d].size(), 0);
  endtask

  initial begin
    rst = 1'b1; req = 4'b1111; req_z = 4'b1111; data = 16'h0000;
    acc[0] = '0; acc[1] = '0; nb[0] = 0; nb[1] = 0;
    last_sof[0] = 0; last_sof[1] = 0;

    // 1. reset and idle
    tick(); tick();
    chk("rst_ack", ack, 0);
    chk("rst_outs", {sout, sv, sof, eof, busy}, 0);
    chk("rst_src_id", sid, 0);
    chk("rst_ack_z", ack_z, 0);
    rst = 1'b0; req = 4'b0000; req_z = 4'b0000;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_ack", ack, 0);

    // 2. single frame, GAP=1
    data = 16'h000B; req = 4'b0001;
    push(0, 0, 4'hB, 0);
    tick();
    chk("t2_ack", ack, 4'b0001);
    chk("t2_sof", sof, 1);
    chk("t2_sout0", sout, 1);
    data = 16'h0000;   // must not disturb the frame in flight
    tick(); chk("t2_sout1", sout, 1);
    tick(); chk("t2_sout2", sout, 0);
    tick(); chk("t2_sout3", sout, 1); chk("t2_eof", eof, 1);
    tick(); chk("t2_gap_sv", sv, 0); chk("t2_gap_busy", busy, 1);
    tick(); chk("t2_idle_busy", busy, 0);

    // 3. contention from pointer 0
    rst = 1'b1; tick(); rst = 1'b0;
    data = 16'h9C3A; req = 4'b1111;
    push(0, 0, 4'hA, 0); push(0, 1, 4'h3, 6);
    push(0, 2, 4'hC, 6); push(0, 3, 4'h9, 6);
    drain(0, 60);

    // 4. fairness: serve req1 (pointer -> 2), then req0+req2
    req = 4'b0010; push(0, 1, 4'h3, 0);
    drain(0, 20);
    req = 4'b0101; push(0, 2, 4'hC, 0); push(0, 0, 4'hA, 6);
    drain(0, 30);

    // 5. back-to-back on the GAP=0 instance
    rst = 1'b1; tick(); rst = 1'b0;
    data = 16'h00A5; req_z = 4'b0011;
    push(1, 0, 4'h5, 0); push(1, 1, 4'hA, 4);
    tick();
    chk("t5_ack0", ack_z, 4'b0001);
    chk("t5_sof0", sof_z, 1);
    tick(); tick(); tick();
    chk("t5_eof0", eof_z, 1);
    tick();
    chk("t5_sof1", sof_z, 1);
    chk("t5_ack1", ack_z, 4'b0010);
    chk("t5_sid1", sid_z, 1);
    drain(1, 20);

    // 6. reset in the middle of a frame
    data = 16'h0C06; req = 4'b0100;
    push(0, 2, 4'hC, 0);
    tick(); chk("t6_sid", sid, 2);
    tick(); tick();
    chk("t6_mid_eof", eof, 0);
    rst = 1'b1;
    tick();
    chk("t6_rst_outs", {sout, sv, sof, eof, busy}, 0);
    chk("t6_rst_ack", ack, 0);
    chk("t6_rst_sid", sid, 0);
    q[0].delete();   // the aborted frame never completes
    rst = 1'b0; req = 4'b0101;
    push(0, 0, 4'h6, 0); push(0, 2, 4'hC, 6);
    tick();
    chk("t6_ack", ack, 4'b0001);
    chk("t6_sid0", sid, 0);
    drain(0, 30);

    chk("final_q0", q[0].size(), 0);
    chk("final_q1", q[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
